traffic_sensor_front: RTL and testbench
=======================================

TRAFFIC_SENSOR_FRONT -- requirements
Module: traffic_sensor_front

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive clock cycles a synchronised sensor level must hold before it is accepted.
REQ-002 Parameter TICK_PERIOD, default 10: clock cycles between state-advance ticks.
REQ-003 Port clock, input, 1: system clock, all flops on posedge.
REQ-004 Port reset, input, 1: reset, synchronous, active-high.
REQ-005 Port sa_raw, input, 1: asynchronous car sensor, street A.
REQ-006 Port sb_raw, input, 1: asynchronous car sensor, street B.
REQ-007 Port ack_a, input, 1: light controller is serving street A (A green).
REQ-008 Port ack_b, input, 1: light controller is serving street B (B green).
REQ-009 Port tick, output, 1: one-cycle pulse that advances the downstream light FSM.
REQ-010 Port SA, output, 1: traffic request, street A, consumed by the light FSM.
REQ-011 Port SB, output, 1: traffic request, street B.
REQ-012 Port sa_stable, output, 1: debounced level, street A.
REQ-013 Port sb_stable, output, 1: debounced level, street B.

Function
REQ-014 Each raw sensor SHALL pass a 2-flop synchroniser before any other logic uses it.
REQ-015 Debounce: a per-channel counter SHALL increment while the synchronised level differs from the stable level, and clear whenever they match.
REQ-016 Debounce: the stable level SHALL toggle, and its counter clear, on the edge where the counter reaches DEBOUNCE_CYCLES-1 with the mismatch still present.
REQ-017 Latency: a raw change held constant SHALL appear on the stable output 2+DEBOUNCE_CYCLES clock edges after it is first sampled.
REQ-018 Glitches: a mismatch lasting fewer than DEBOUNCE_CYCLES synchronised cycles SHALL leave the stable level unchanged.
REQ-019 Pending latch: per channel, pending_next = 1 if stable=1; otherwise 0 if (ack & tick); otherwise hold.
REQ-020 Set priority: set SHALL win over clear when both conditions occur in the same cycle.
REQ-021 SA SHALL equal pending_a OR sa_stable, and SB SHALL equal pending_b OR sb_stable; both are combinational OR of registered signals only.
REQ-022 Tick counter SHALL count 0..TICK_PERIOD-1 and wrap to 0.
REQ-023 tick SHALL be high exactly while count == TICK_PERIOD-1, giving one pulse per TICK_PERIOD cycles.
REQ-024 Counter widths: tick counter $clog2(TICK_PERIOD) bits, debounce counter $clog2(DEBOUNCE_CYCLES+1) bits; no counter SHALL overflow.
REQ-025 Channels A and B SHALL be fully independent; simultaneous events on both are handled in parallel.
REQ-026 Elaboration SHALL fail if DEBOUNCE_CYCLES < 1 or TICK_PERIOD < 2.

Reset
REQ-027 While reset=1 at a clock edge, all of the following SHALL be 0: synchroniser flops, stable levels, debounce counters, pending latches and the tick counter.
REQ-028 Outputs during reset: tick=0, SA=SB=0, sa_stable=sb_stable=0.
REQ-029 First tick SHALL occur TICK_PERIOD cycles after the first edge with reset=0.
REQ-030 Reset mid-operation SHALL discard pending requests and partial debounce counts within one edge.

Structure
REQ-031 Package traffic_pkg SHALL hold the default DEBOUNCE_CYCLES and TICK_PERIOD constants, shared with the light FSM bench.
REQ-032 Sub-module sensor_debounce (synchroniser + debounce counter + stable flop) SHALL be instantiated twice.
REQ-033 The tick generator and pending latches SHALL live in the top module.

Verification (DEBOUNCE_CYCLES=4, TICK_PERIOD=10)
REQ-034 Reset held 3 cycles, then released -> all outputs 0; tick first high on cycle 10 after release, then every 10 cycles.
REQ-035 sa_raw 0->1 held -> sa_stable and SA rise on the 6th edge; a 3-cycle sa_raw pulse -> sa_stable stays 0.
REQ-036 sb_raw high 8 cycles then low, ack_b=0 -> SB stays 1 after sb_stable falls; ack_b=1 on the next tick -> SB=0 on the following cycle.
REQ-037 sa_stable=1 while ack_a=1 and tick=1 -> pending_a stays 1 (set wins) and SA stays 1.
REQ-038 Both sensors toggle on the same edge -> sa_stable and sb_stable change on the same cycle.
REQ-039 Reset asserted with pending_a=1 and debounce count 2 -> SA=0 after one edge; no stale toggle after release.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: default timing constants shared by the sensor front end and the light FSM bench
package traffic_pkg;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_TICK_PERIOD = 10;
endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: 2-flop synchroniser, debounce counter and stable level flop for one sensor
module sensor_debounce
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic stable
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1, s2;
  logic [CW-1:0] cnt;
  logic done;
  assign done = cnt == CW'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clock)
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      stable <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      stable <= (s2 != stable && done) ? ~stable : stable;
      cnt <= (s2 == stable || done) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/traffic_sensor_front.sv
// traffic_sensor_front: debounced car sensors, latched traffic requests and the light FSM tick
module traffic_sensor_front
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int TICK_PERIOD = DEF_TICK_PERIOD
) (
  input  logic clock,
  input  logic reset,
  input  logic sa_raw,
  input  logic sb_raw,
  input  logic ack_a,
  input  logic ack_b,
  output logic tick,
  output logic SA,
  output logic SB,
  output logic sa_stable,
  output logic sb_stable
);
  localparam int TW = $clog2(TICK_PERIOD);
  if (DEBOUNCE_CYCLES < 1 || TICK_PERIOD < 2) begin : g_bad_params
    $error("traffic_sensor_front: DEBOUNCE_CYCLES must be >= 1 and TICK_PERIOD >= 2");
  end
  logic [TW-1:0] cnt;
  logic pend_a, pend_b;
  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clock(clock), .reset(reset), .raw(sa_raw), .stable(sa_stable)
  );
  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clock(clock), .reset(reset), .raw(sb_raw), .stable(sb_stable)
  );
  assign tick = cnt == TW'(TICK_PERIOD - 1);
  assign SA = pend_a | sa_stable;
  assign SB = pend_b | sb_stable;
  always_ff @(posedge clock)
    if (reset) begin
      cnt <= '0;
      pend_a <= 1'b0;
      pend_b <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      pend_a <= sa_stable | (pend_a & ~(ack_a & tick));
      pend_b <= sb_stable | (pend_b & ~(ack_b & tick));
    end
endmodule

// File: tb/tb_traffic_sensor_front.sv
// tb_traffic_sensor_front: directed scenarios plus randomized run against a behavioural model
module tb_traffic_sensor_front;
  import traffic_pkg::*;
  localparam int D = DEF_DEBOUNCE_CYCLES;
  localparam int P = DEF_TICK_PERIOD;
  logic clock = 1'b0, reset = 1'b1, sa_raw = 1'b0, sb_raw = 1'b0, ack_a = 1'b0, ack_b = 1'b0;
  logic tick, SA, SB, sa_stable, sb_stable;
  int total = 0, bad = 0;

  traffic_sensor_front #(.DEBOUNCE_CYCLES(D), .TICK_PERIOD(P)) dut (
    .clock(clock), .reset(reset), .sa_raw(sa_raw), .sb_raw(sb_raw),
    .ack_a(ack_a), .ack_b(ack_b), .tick(tick), .SA(SA), .SB(SB),
    .sa_stable(sa_stable), .sb_stable(sb_stable)
  );

  always #5 clock = ~clock;

  bit m_q[2][$];
  bit m_stable[2], m_pend[2];
  int m_run[2];
  int m_cyc = 0;

  function automatic bit m_tick();
    return (m_cyc % P) == P - 1;
  endfunction

  always @(posedge clock) begin : model
    bit raw_v[2], ack_v[2];
    bit t, s;
    raw_v[0] = sa_raw; raw_v[1] = sb_raw;
    ack_v[0] = ack_a;  ack_v[1] = ack_b;
    t = m_tick();
    for (int c = 0; c < 2; c++) begin
      if (reset) begin
        m_q[c] = {};
        m_q[c].push_back(1'b0);
        m_q[c].push_back(1'b0);
        m_stable[c] = 1'b0;
        m_pend[c] = 1'b0;
        m_run[c] = 0;
      end else begin
        s = m_q[c].pop_front();
        m_q[c].push_back(raw_v[c]);
        m_pend[c] = m_stable[c] ? 1'b1 : (ack_v[c] && t) ? 1'b0 : m_pend[c];
        if (s == m_stable[c]) m_run[c] = 0;
        else begin
          m_run[c]++;
          if (m_run[c] == D) begin
            m_stable[c] = ~m_stable[c];
            m_run[c] = 0;
          end
        end
      end
    end
    m_cyc = reset ? 0 : m_cyc + 1;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1; sa_raw = 1'b0; sb_raw = 1'b0; ack_a = 1'b0; ack_b = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1; sa_raw = 1'b1; sb_raw = 1'b1; ack_a = 1'b1; ack_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({tick, SA, SB, sa_stable, sb_stable} !== 5'b0) begin
        bad++;
        $display("FAIL reset_outputs cycle=%0d got={tick,SA,SB,sas,sbs}=%b exp=00000", i, {tick, SA, SB, sa_stable, sb_stable});
      end
    end
    sa_raw = 1'b0; sb_raw = 1'b0; ack_a = 1'b0; ack_b = 1'b0;
    reset = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      step();
      total++;
      if (tick !== ((i % P) == P - 1)) begin
        bad++;
        $display("FAIL tick_period cycle=%0d got=%b exp=%b", i + 1, tick, (i % P) == P - 1);
      end
      total++;
      if ({SA, SB} !== 2'b00) begin
        bad++;
        $display("FAIL idle_requests cycle=%0d got=%b exp=00", i + 1, {SA, SB});
      end
    end
  endtask

  task automatic test_latency();
    apply_reset();
    sa_raw = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      total++;
      if ({sa_stable, SA} !== {2{k >= 2 + D}}) begin
        bad++;
        $display("FAIL latency edge=%0d got={sas,SA}=%b exp=%b", k, {sa_stable, SA}, {2{k >= 2 + D}});
      end
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    sa_raw = 1'b1;
    step(D - 1);
    sa_raw = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      total++;
      if ({sa_stable, SA} !== 2'b00) begin
        bad++;
        $display("FAIL glitch edge=%0d got={sas,SA}=%b exp=00", k, {sa_stable, SA});
      end
    end
  endtask

  task automatic test_pending_hold();
    bit found;
    apply_reset();
    sb_raw = 1'b1;
    step(8);
    sb_raw = 1'b0;
    step(8);
    total++;
    if ({sb_stable, SB} !== 2'b01) begin
      bad++;
      $display("FAIL pending_hold got={sbs,SB}=%b exp=01", {sb_stable, SB});
    end
    ack_b = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 2 * P && !found; i++) begin
      if (tick) found = 1'b1;
      else step();
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL pending_tick_wait got=no_tick exp=tick within %0d cycles", 2 * P);
    end
    total++;
    if (SB !== 1'b1) begin
      bad++;
      $display("FAIL pending_at_tick got=%b exp=1", SB);
    end
    step();
    total++;
    if (SB !== 1'b0) begin
      bad++;
      $display("FAIL pending_clear got=%b exp=0", SB);
    end
    ack_b = 1'b0;
  endtask

  task automatic test_set_wins();
    bit found;
    apply_reset();
    ack_a = 1'b1;
    sa_raw = 1'b1;
    step(D + 3);
    found = 1'b0;
    for (int i = 0; i < 2 * P && !found; i++) begin
      if (tick) found = 1'b1;
      else step();
    end
    total++;
    if (!found || SA !== 1'b1) begin
      bad++;
      $display("FAIL set_wins_tick got=found%b,SA%b exp=found1,SA1", found, SA);
    end
    step(5);
    sa_raw = 1'b0;
    step(2 + D);
    total++;
    if ({sa_stable, SA} !== 2'b01) begin
      bad++;
      $display("FAIL set_wins_hold got={sas,SA}=%b exp=01", {sa_stable, SA});
    end
    step(P);
    total++;
    if (SA !== 1'b0) begin
      bad++;
      $display("FAIL set_wins_later_clear got=%b exp=0", SA);
    end
    ack_a = 1'b0;
  endtask

  task automatic test_simultaneous();
    apply_reset();
    sa_raw = 1'b1; sb_raw = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      if (k == 9) begin
        sa_raw = 1'b0; sb_raw = 1'b0;
      end
      step();
      total++;
      if ({sa_stable, sb_stable} !== {2{(k >= 2 + D) && (k < 10 + D)}}) begin
        bad++;
        $display("FAIL simultaneous edge=%0d got={sas,sbs}=%b exp=%b", k, {sa_stable, sb_stable},
                 {2{(k >= 2 + D) && (k < 10 + D)}});
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    sa_raw = 1'b1;
    step(D + 3);
    sa_raw = 1'b0;
    step(D + 3);
    total++;
    if ({sa_stable, SA} !== 2'b01) begin
      bad++;
      $display("FAIL mid_setup got={sas,SA}=%b exp=01", {sa_stable, SA});
    end
    sa_raw = 1'b1;
    step(4);
    reset = 1'b1;
    step();
    total++;
    if ({sa_stable, SA} !== 2'b00) begin
      bad++;
      $display("FAIL mid_reset got={sas,SA}=%b exp=00", {sa_stable, SA});
    end
    sa_raw = 1'b0;
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      total++;
      if ({sa_stable, SA} !== 2'b00) begin
        bad++;
        $display("FAIL mid_stale edge=%0d got={sas,SA}=%b exp=00", k, {sa_stable, SA});
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      total++;
      if (tick !== m_tick()) begin
        bad++;
        $display("FAIL rnd_tick i=%0d got=%b exp=%b", i, tick, m_tick());
      end
      total++;
      if ({sa_stable, sb_stable} !== {m_stable[0], m_stable[1]}) begin
        bad++;
        $display("FAIL rnd_stable i=%0d got=%b exp=%b", i, {sa_stable, sb_stable}, {m_stable[0], m_stable[1]});
      end
      total++;
      if ({SA, SB} !== {m_pend[0] | m_stable[0], m_pend[1] | m_stable[1]}) begin
        bad++;
        $display("FAIL rnd_request i=%0d got=%b exp=%b", i, {SA, SB},
                 {m_pend[0] | m_stable[0], m_pend[1] | m_stable[1]});
      end
      if ($urandom_range(7) == 0) sa_raw = ~sa_raw;
      if ($urandom_range(7) == 0) sb_raw = ~sb_raw;
      ack_a = 1'($urandom_range(1));
      ack_b = 1'($urandom_range(1));
      reset = $urandom_range(149) == 0;
      step();
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_pending_hold();
    test_set_wins();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
